// File: rtl/divident_rebuild17.sv
// Rebuilds a 32-bit dividend from a (quotient, remainder) pair for divisor 17.
// Four register stages; malformed pairs (remainder > 16 or 32-bit overflow) are flagged and counted.
module divident_rebuild17 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mark_in,
   input  logic [27:0] quotient,
   input  logic [4:0]  reminder,
   output logic        mark_out,
   output logic [31:0] divident,
   output logic        err_out,
   output logic [15:0] err_cnt
);

   logic [2:0]  mark_p_q,   mark_p_d;
   logic [27:0] quo1_q,     quo1_d;
   logic [4:0]  rem1_q,     rem1_d;
   logic        bad1_q,     bad1_d;
   logic [32:0] q17_q,      q17_d;
   logic [4:0]  rem2_q,     rem2_d;
   logic        bad2_q,     bad2_d;
   logic [32:0] sum_q,      sum_d;
   logic        bad3_q,     bad3_d;
   logic        mark_out_q, mark_out_d;
   logic [31:0] div_q,      div_d;
   logic        err_q,      err_d;
   logic [15:0] cnt_q,      cnt_d;
   logic        word_err_s;

   // Next-state for all pipeline stages, the output stage and the error counter
   always_comb begin
      mark_p_d   = {mark_p_q[1:0], mark_in};
      quo1_d     = quo1_q;
      rem1_d     = rem1_q;
      bad1_d     = bad1_q;
      q17_d      = q17_q;
      rem2_d     = rem2_q;
      bad2_d     = bad2_q;
      sum_d      = sum_q;
      bad3_d     = bad3_q;
      mark_out_d = mark_p_q[2];
      div_d      = div_q;
      err_d      = 1'b0;
      cnt_d      = cnt_q;
      word_err_s = bad3_q | sum_q[32];

      if (mark_in) begin
         quo1_d = quotient;
         rem1_d = reminder;
         bad1_d = (reminder > 5'd16);
      end else begin
         quo1_d = quo1_q;
      end

      // q*17 as q*16 + q; 28 bits * 17 always fits in 33 bits
      if (mark_p_q[0]) begin
         q17_d  = {1'b0, quo1_q, 4'b0000} + {5'b00000, quo1_q};
         rem2_d = rem1_q;
         bad2_d = bad1_q;
      end else begin
         q17_d  = q17_q;
      end

      if (mark_p_q[1]) begin
         sum_d  = q17_q + {28'd0, rem2_q};
         bad3_d = bad2_q;
      end else begin
         sum_d  = sum_q;
      end

      if (mark_p_q[2]) begin
         err_d = word_err_s;
         div_d = word_err_s ? 32'd0 : sum_q[31:0];
      end else begin
         err_d = 1'b0;
         div_d = div_q;
      end

      if (mark_out_q && err_q && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State registers; reset discards everything in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mark_p_q   <= 3'b000;
         quo1_q     <= 28'd0;
         rem1_q     <= 5'd0;
         bad1_q     <= 1'b0;
         q17_q      <= 33'd0;
         rem2_q     <= 5'd0;
         bad2_q     <= 1'b0;
         sum_q      <= 33'd0;
         bad3_q     <= 1'b0;
         mark_out_q <= 1'b0;
         div_q      <= 32'd0;
         err_q      <= 1'b0;
         cnt_q      <= 16'd0;
      end else begin
         mark_p_q   <= mark_p_d;
         quo1_q     <= quo1_d;
         rem1_q     <= rem1_d;
         bad1_q     <= bad1_d;
         q17_q      <= q17_d;
         rem2_q     <= rem2_d;
         bad2_q     <= bad2_d;
         sum_q      <= sum_d;
         bad3_q     <= bad3_d;
         mark_out_q <= mark_out_d;
         div_q      <= div_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
      end
   end

   assign mark_out = mark_out_q;
   assign divident = div_q;
   assign err_out  = err_q;
   assign err_cnt  = cnt_q;

endmodule

// File: tb/tb_divident_rebuild17.sv
// Directed bench for divident_rebuild17: a reference delay line of expected results is
// compared against the outputs every cycle, plus targeted checks on the error counter.
module tb_divident_rebuild17;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mark_in = 1'b0;
   logic [27:0] quotient = 28'd0;
   logic [4:0]  reminder = 5'd0;
   logic        mark_out;
   logic [31:0] divident;
   logic        err_out;
   logic [15:0] err_cnt;

   int checks = 0;
   int errors = 0;

   // expected pipeline: index 0 = word sampled at latest edge, 3 = word now at output
   logic        em   [4];
   logic        eerr [4];
   logic [31:0] ediv [4];
   logic [31:0] last_div = 32'd0;
   logic [15:0] ecnt = 16'd0;
   logic        mon_en = 1'b0;

   divident_rebuild17 dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .mark_in  (mark_in),
      .quotient (quotient),
      .reminder (reminder),
      .mark_out (mark_out),
      .divident (divident),
      .err_out  (err_out),
      .err_cnt  (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         em[i] = 1'b0; eerr[i] = 1'b0; ediv[i] = 32'd0;
      end
      last_div = 32'd0;
      ecnt = 16'd0;
   endtask

   // one clock with the given inputs; model advances at the same edge
   task automatic tick(input logic m, input logic [27:0] q, input logic [4:0] r);
      logic [32:0] x;
      logic        e;
      mark_in  = m;
      quotient = q;
      reminder = r;
      @(posedge clk);
      if (!rst_n) begin
         model_clear();
      end else begin
         if (em[3] && eerr[3] && ecnt != 16'hFFFF) ecnt = ecnt + 16'd1;
         if (em[3]) last_div = ediv[3];
         for (int i = 3; i > 0; i--) begin
            em[i] = em[i-1]; eerr[i] = eerr[i-1]; ediv[i] = ediv[i-1];
         end
         x = 33'(q) * 33'd17 + 33'(r);
         e = (r > 5'd16) || x[32];
         em[0]   = m;
         eerr[0] = m & e;
         ediv[0] = e ? 32'd0 : x[31:0];
      end
      #1;
   endtask

   // per-cycle comparison of outputs against the expected delay line
   always @(negedge clk) begin
      if (mon_en) begin
         check_val("mark_out", {31'd0, mark_out}, {31'd0, em[3]});
         check_val("err_out", {31'd0, err_out}, {31'd0, em[3] & eerr[3]});
         check_val("divident", divident, em[3] ? ediv[3] : last_div);
         check_val("err_cnt", {16'd0, err_cnt}, {16'd0, ecnt});
      end
   end

   initial begin
      logic [31:0] x;
      logic [6:0]  gap_pat;
      model_clear();
      #12;
      check_val("rst_mark", {31'd0, mark_out}, 32'd0);
      check_val("rst_div", divident, 32'd0);
      check_val("rst_err", {31'd0, err_out}, 32'd0);
      check_val("rst_cnt", {16'd0, err_cnt}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      mon_en = 1'b1;

      // back-to-back legal words, then explicit latency check
      tick(1'b1, 28'd1, 5'd0);
      tick(1'b1, 28'd17351017, 5'd6);
      tick(1'b0, 28'd0, 5'd0);
      tick(1'b0, 28'd0, 5'd0);
      @(negedge clk);
      check_val("lat_first", {31'd0, mark_out}, 32'd1);
      check_val("lat_first_val", divident, 32'd17);
      tick(1'b0, 28'd0, 5'd0);
      @(negedge clk);
      check_val("lat_second_val", divident, 32'd294967295);
      repeat (3) tick(1'b0, 28'd0, 5'd0);

      // overflow boundary and bad remainder
      tick(1'b1, 28'h0F0F0F0F, 5'd0);
      tick(1'b1, 28'h0F0F0F0F, 5'd1);
      tick(1'b1, 28'd5, 5'd17);
      tick(1'b1, 28'h0FFFFFFF, 5'd31);
      repeat (6) tick(1'b0, 28'd0, 5'd0);
      check_val("errcnt_three", {16'd0, err_cnt}, 32'd3);
      check_val("hold_after_err", divident, 32'd0);

      // gapped stream; divident must hold across gaps
      gap_pat = 7'b1001011;
      for (int i = 0; i < 7; i++) begin
         x = $urandom;
         tick(gap_pat[i], 28'(x / 32'd17), 5'(x % 32'd17));
      end
      repeat (5) tick(1'b0, 28'd0, 5'd0);

      // round trip with random dividends
      for (int i = 0; i < 2000; i++) begin
         x = $urandom;
         tick(1'b1, 28'(x / 32'd17), 5'(x % 32'd17));
      end
      repeat (5) tick(1'b0, 28'd0, 5'd0);

      // reset with three words in flight
      tick(1'b1, 28'd100, 5'd3);
      tick(1'b1, 28'd200, 5'd4);
      tick(1'b1, 28'd300, 5'd5);
      rst_n = 1'b0;
      model_clear();
      #1;
      check_val("midrst_mark", {31'd0, mark_out}, 32'd0);
      check_val("midrst_div", divident, 32'd0);
      check_val("midrst_cnt", {16'd0, err_cnt}, 32'd0);
      tick(1'b0, 28'd0, 5'd0);
      rst_n = 1'b1;
      repeat (6) tick(1'b0, 28'd0, 5'd0);

      // counter saturation
      for (int i = 0; i < 65540; i++) tick(1'b1, 28'd0, 5'd17);
      repeat (6) tick(1'b0, 28'd0, 5'd0);
      check_val("errcnt_sat", {16'd0, err_cnt}, 32'h0000FFFF);
      tick(1'b1, 28'd7, 5'd20);
      repeat (6) tick(1'b0, 28'd0, 5'd0);
      check_val("errcnt_sat_hold", {16'd0, err_cnt}, 32'h0000FFFF);

      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
